// File: rtl/imem_boot_loader_pkg.sv
// Shared state encoding and default sizing for the imem boot loader.
// IMEM_ADDR_WIDTH, when defined by the build, sets the default imem word-address width.
`ifndef IMEM_ADDR_WIDTH
`define IMEM_ADDR_WIDTH 10
`endif

package imem_boot_loader_pkg;

  localparam int DEFAULT_ADDR_WIDTH = `IMEM_ADDR_WIDTH;
  localparam int DEFAULT_LEN_WIDTH  = 16;

  typedef enum logic [2:0] {
    ST_LEN0    = 3'd0,
    ST_LEN1    = 3'd1,
    ST_DATA    = 3'd2,
    ST_CSUM    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_RUN     = 3'd5,
    ST_ERR     = 3'd6
  } boot_state_t;

  function automatic logic state_takes_bytes(input boot_state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_boot_loader_word_asm.sv
// Little-endian byte-to-word assembler: collects four accepted bytes and
// presents the finished word with a one-cycle valid pulse on the following cycle.
module boot_word_asm
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        fire_i,
    input  logic [7:0]  byte_i,
    output logic        last_byte_o,
    output logic [31:0] word_o,
    output logic        word_vld_o
);

    logic [1:0]  cnt_q;
    logic [23:0] sh_q;
    logic [31:0] word_q;
    logic        vld_q;

    // Bytes enter at the top so the first byte ends up in bits [7:0].
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            sh_q   <= 24'd0;
            word_q <= 32'd0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (clear_i) begin
                cnt_q <= 2'd0;
            end else if (fire_i) begin
                cnt_q <= cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    word_q <= {byte_i, sh_q};
                    vld_q  <= 1'b1;
                end else begin
                    sh_q <= {byte_i, sh_q[23:8]};
                end
            end
        end
    end

    assign last_byte_o = (cnt_q == 2'd3);
    assign word_o      = word_q;
    assign word_vld_o  = vld_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot sequencer: loads a length-prefixed image into imem and holds the core in reset until done.
// Define BOOT_CSUM_EN to require a trailing XOR checksum byte after the data.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            i_byte,
    input  logic                  i_byte_vld,
    output logic                  o_byte_rdy,
    input  logic                  i_reload,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [31:0]           o_imem_data,
    output logic                  o_imem_we,
    output logic                  o_core_rst_n,
    output logic                  o_done,
    output logic                  o_err
);

    localparam logic [LEN_WIDTH:0] CAPACITY = (LEN_WIDTH+1)'(1) << ADDR_WIDTH;
`ifdef BOOT_CSUM_EN
    localparam boot_state_t ST_AFTER_DATA = ST_CSUM;
`else
    localparam boot_state_t ST_AFTER_DATA = ST_RELEASE;
`endif

    boot_state_t          state_q, state_d;
    logic [7:0]           len_lo_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH:0]   widx_q;
    logic                 core_rst_n_q, core_rst_n_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 byte_rdy;
    logic                 byte_fire;
    logic                 data_fire;
    logic                 reload_take;
    logic [LEN_WIDTH-1:0] hdr_len;
    logic                 hdr_too_big;
    logic                 asm_last_byte;
    logic                 word_last;
    logic [31:0]          asm_word;
    logic                 asm_word_vld;

    assign byte_fire   = i_byte_vld && byte_rdy;
    assign data_fire   = byte_fire && (state_q == ST_DATA);
    assign reload_take = i_reload && ((state_q == ST_RUN) || (state_q == ST_ERR));
    assign hdr_len     = LEN_WIDTH'({i_byte, len_lo_q});
    assign hdr_too_big = {1'b0, hdr_len} > CAPACITY;
    assign word_last   = data_fire && asm_last_byte &&
                         ((widx_q + (LEN_WIDTH+1)'(1)) == {1'b0, len_q});

`ifdef BOOT_CSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk) begin
        if (!rst_n || state_q == ST_LEN0) begin
            csum_q <= 8'd0;
        end else if (data_fire) begin
            csum_q <= csum_q ^ i_byte;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_LEN0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LEN0: if (byte_fire) state_d = ST_LEN1;
            ST_LEN1: begin
                if (byte_fire) begin
                    if (hdr_len == '0)    state_d = ST_AFTER_DATA;
                    else if (hdr_too_big) state_d = ST_ERR;
                    else                  state_d = ST_DATA;
                end
            end
            ST_DATA: if (word_last) state_d = ST_AFTER_DATA;
`ifdef BOOT_CSUM_EN
            ST_CSUM: if (byte_fire) state_d = (i_byte == csum_q) ? ST_RELEASE : ST_ERR;
`endif
            ST_RELEASE: state_d = ST_RUN;
            ST_RUN, ST_ERR: if (i_reload) state_d = ST_LEN0;
            default: state_d = ST_LEN0;
        endcase
    end

    // Ready is gated by rst_n so it reads 0 while reset is held, even though the state is LEN0.
    always_comb begin
        byte_rdy     = rst_n && state_takes_bytes(state_q);
        core_rst_n_d = (state_d == ST_RUN);
        done_d       = (state_d == ST_RUN);
        err_d        = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_lo_q     <= 8'd0;
            len_q        <= '0;
            widx_q       <= '0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            core_rst_n_q <= core_rst_n_d;
            done_q       <= done_d;
            err_q        <= err_d;
            if (byte_fire && state_q == ST_LEN0) len_lo_q <= i_byte;
            if (byte_fire && state_q == ST_LEN1) len_q <= hdr_len;
            // The index advances after its write strobe, so it names the word being written.
            if (reload_take)       widx_q <= '0;
            else if (asm_word_vld) widx_q <= widx_q + (LEN_WIDTH+1)'(1);
        end
    end

    boot_word_asm u_word_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (reload_take),
        .fire_i      (data_fire),
        .byte_i      (i_byte),
        .last_byte_o (asm_last_byte),
        .word_o      (asm_word),
        .word_vld_o  (asm_word_vld)
    );

    assign o_byte_rdy   = byte_rdy;
    assign o_imem_addr  = widx_q[ADDR_WIDTH-1:0];
    assign o_imem_data  = asm_word;
    assign o_imem_we    = asm_word_vld;
    assign o_core_rst_n = core_rst_n_q;
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed-vector bench for imem_boot_loader (4-word imem); expected writes go
// through a queue checked by an independent monitor. Honours BOOT_CSUM_EN.
module tb_imem_boot_loader;

    localparam int AW = 2;
    localparam int W  = AW + 32;

    logic          clk;
    logic          rst_n;
    logic [7:0]    i_byte;
    logic          i_byte_vld;
    logic          o_byte_rdy;
    logic          i_reload;
    logic [AW-1:0] o_imem_addr;
    logic [31:0]   o_imem_data;
    logic          o_imem_we;
    logic          o_core_rst_n;
    logic          o_done;
    logic          o_err;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [7:0]   stream_q[$];

    imem_boot_loader #(.ADDR_WIDTH(AW), .LEN_WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_byte       (i_byte),
        .i_byte_vld   (i_byte_vld),
        .o_byte_rdy   (o_byte_rdy),
        .i_reload     (i_reload),
        .o_imem_addr  (o_imem_addr),
        .o_imem_data  (o_imem_data),
        .o_imem_we    (o_imem_we),
        .o_core_rst_n (o_core_rst_n),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every write strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (o_imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         o_imem_addr, o_imem_data);
            end else begin
                check("imem_write", 64'({o_imem_addr, o_imem_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int waited;
        if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
                i_byte_vld = 1'b0;
                i_byte     = 8'($urandom);
                step();
            end
        end
        i_byte     = b;
        i_byte_vld = 1'b1;
        waited     = 0;
        while (!o_byte_rdy && waited < 40) begin
            step();
            waited++;
        end
        if (!o_byte_rdy) begin
            checks++;
            failures++;
            $display("FAIL byte_accept: got rdy 0 for 40 cycles expected rdy 1 (byte %0h)", b);
        end else begin
            step();
        end
        i_byte_vld = 1'b0;
    endtask

    task automatic send_stream(input bit rnd);
        foreach (stream_q[i]) send_byte(stream_q[i], rnd);
        stream_q.delete();
    endtask

    task automatic pulse_reload();
        i_reload = 1'b1;
        step();
        i_reload = 1'b0;
        check("reload_core_rst_n", 64'(o_core_rst_n), 64'(0));
        check("reload_done", 64'(o_done), 64'(0));
        check("reload_err", 64'(o_err), 64'(0));
        check("reload_addr", 64'(o_imem_addr), 64'(0));
    endtask

    // Called one cycle after the last byte was accepted.
    task automatic expect_run(input string tag);
        check({tag, "_rst_low_in_release"}, 64'(o_core_rst_n), 64'(0));
        step();
        check({tag, "_core_rst_n"}, 64'(o_core_rst_n), 64'(1));
        check({tag, "_done"}, 64'(o_done), 64'(1));
        check({tag, "_rdy_in_run"}, 64'(o_byte_rdy), 64'(0));
    endtask

    task automatic expect_err(input string tag);
        check({tag, "_err"}, 64'(o_err), 64'(1));
        check({tag, "_core_rst_n"}, 64'(o_core_rst_n), 64'(0));
        check({tag, "_done"}, 64'(o_done), 64'(0));
        check({tag, "_rdy_in_err"}, 64'(o_byte_rdy), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"}, 64'(o_byte_rdy), 64'(0));
        check({tag, "_addr"}, 64'(o_imem_addr), 64'(0));
        check({tag, "_data"}, 64'(o_imem_data), 64'(0));
        check({tag, "_we"}, 64'(o_imem_we), 64'(0));
        check({tag, "_core_rst_n"}, 64'(o_core_rst_n), 64'(0));
        check({tag, "_done"}, 64'(o_done), 64'(0));
        check({tag, "_err"}, 64'(o_err), 64'(0));
    endtask

    initial begin
        rst_n      = 1'b0;
        i_byte     = 8'h00;
        i_byte_vld = 1'b0;
        i_reload   = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // two-word image, one byte per cycle
        stream_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef BOOT_CSUM_EN
        stream_q.push_back(8'h7C);
`endif
        exp_q.push_back({2'd0, 32'h0000_0013});
        exp_q.push_back({2'd1, 32'h0000_006F});
        send_stream(1'b0);
        expect_run("img1");

        // reload, then a new image with randomly gapped valid
        pulse_reload();
        stream_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef BOOT_CSUM_EN
        stream_q.push_back(8'h2A);
`endif
        exp_q.push_back({2'd0, 32'h1234_5678});
        exp_q.push_back({2'd1, 32'hDEAD_BEEF});
        send_stream(1'b1);
        expect_run("img2_gapped");

        // zero-length image
        pulse_reload();
        stream_q = '{8'h00, 8'h00};
`ifdef BOOT_CSUM_EN
        stream_q.push_back(8'h00);
`endif
        send_stream(1'b0);
        expect_run("zero_len");

`ifdef BOOT_CSUM_EN
        pulse_reload();
        stream_q = '{8'h00, 8'h00, 8'h01};
        send_stream(1'b0);
        expect_err("zero_len_bad_csum");
`endif

        // one word more than the 4-word imem holds
        pulse_reload();
        stream_q = '{8'h05, 8'h00};
        send_stream(1'b0);
        expect_err("too_long");
        repeat (3) step();
        check("too_long_core_held", 64'(o_core_rst_n), 64'(0));

        // exactly full imem, leaving ERR through reload
        pulse_reload();
        stream_q = '{8'h04, 8'h00};
        for (int i = 0; i < 16; i++) stream_q.push_back(8'(8'h10 + i));
`ifdef BOOT_CSUM_EN
        stream_q.push_back(8'h00);
`endif
        exp_q.push_back({2'd0, 32'h1312_1110});
        exp_q.push_back({2'd1, 32'h1716_1514});
        exp_q.push_back({2'd2, 32'h1B1A_1918});
        exp_q.push_back({2'd3, 32'h1F1E_1D1C});
        send_stream(1'b0);
        expect_run("full_mem");

`ifdef BOOT_CSUM_EN
        pulse_reload();
        stream_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        exp_q.push_back({2'd0, 32'h4433_2211});
        send_stream(1'b0);
        expect_run("csum_good");

        pulse_reload();
        stream_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        exp_q.push_back({2'd0, 32'h4433_2211});
        send_stream(1'b0);
        expect_err("csum_bad");
`endif

        // reset in the middle of DATA, after one word was written
        pulse_reload();
        stream_q = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        exp_q.push_back({2'd0, 32'h0403_0201});
        send_stream(1'b0);
        rst_n = 1'b0;
        step();
        check_reset_outputs("mid_data_reset");
        rst_n = 1'b1;
        step();

        // loader recovers after the abort
        stream_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef BOOT_CSUM_EN
        stream_q.push_back(8'h00);
`endif
        exp_q.push_back({2'd0, 32'hDDCC_BBAA});
        send_stream(1'b1);
        expect_run("after_abort");

        // final report
        repeat (3) step();
        check("writes_outstanding", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Byte-stream boot sequencer for instruction memory.
- Receives a length-prefixed program image over a valid/ready byte interface (UART receiver or debug bridge), assembles little-endian 32-bit words and drives the imem write port.
- Holds the core in reset for the whole load and releases it only once the image is fully written.
- Sits in the top level between the byte source, the imem write port and the core's rst_n.

Parameters:
- ADDR_WIDTH, 10, imem word-address width; capacity = 2**ADDR_WIDTH words.
- LEN_WIDTH, 16, width of the word-count header field.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- i_byte  input  8  incoming stream byte
- i_byte_vld  input  1  i_byte is valid this cycle
- o_byte_rdy  output  1  loader accepts a byte this cycle
- i_reload  input  1  single-cycle request to restart loading
- o_imem_addr  output  ADDR_WIDTH  word address for imem write
- o_imem_data  output  32  word to write
- o_imem_we  output  1  one-cycle write strobe
- o_core_rst_n  output  1  active-low reset for core
- o_done  output  1  image loaded, core running
- o_err  output  1  load aborted

Behaviour:
- Reset is synchronous and active-low; one clock. Reset values: o_byte_rdy=0, o_imem_addr=0, o_imem_data=0, o_imem_we=0, o_core_rst_n=0, o_done=0, o_err=0; state=LEN0.
- Handshake: a byte transfers on a rising edge where i_byte_vld && o_byte_rdy.
- o_byte_rdy is combinational from state: 1 in LEN0, LEN1, DATA and CSUM; 0 elsewhere.
- LEN0: latch len[7:0] on transfer, then go to LEN1.
- LEN1: latch len[15:8] on transfer.
  - len==0: go to CSUM if BOOT_CSUM_EN, else RELEASE.
  - len > 2**ADDR_WIDTH: go to ERR.
  - Otherwise go to DATA.
- DATA:
  - 2-bit byte counter; byte k goes to word bits [8k+7:8k] (little-endian).
  - On the 4th byte transfer, the next cycle has o_imem_we=1 for exactly one cycle, o_imem_data = the assembled word, o_imem_addr = word index (starting at 0, +1 per word).
  - After the word with index len-1 is issued, go to CSUM if BOOT_CSUM_EN, else RELEASE.
  - Byte transfers may be back-to-back every cycle; no bubbles are required.
- RELEASE: one cycle, so the final imem write commits. Then go to RUN.
- RUN: o_core_rst_n=1, o_done=1.
- ERR: o_err=1, o_core_rst_n stays 0.
- i_reload:
  - Sampled in RUN or ERR: next state LEN0, clears o_done/o_err, clears address and byte counters, drives o_core_rst_n=0 from the next cycle.
  - Ignored in LEN0/LEN1/DATA/CSUM/RELEASE.
- Latency: the last byte is accepted at edge N. The last write strobe is in cycle N+1, RELEASE is in N+1, and o_core_rst_n rises in cycle N+2.
- o_core_rst_n is registered and low in every state except RUN.
- rst_n asserted mid-load: abort immediately, all outputs return to reset values, and the partial image is left in imem.
- Counters:
  - Word counter is LEN_WIDTH+1 bits, so a full memory (len == 2**ADDR_WIDTH) does not overflow.
  - o_imem_addr is the low ADDR_WIDTH bits of the word index.

Optional Feature:
- Macro BOOT_CSUM_EN.
- When defined:
  - After the data (or after a zero length), state CSUM accepts one byte.
  - The running XOR of all data bytes (header excluded), reset to 0x00 at LEN0, is compared with it.
  - Match: go to RELEASE. Mismatch: go to ERR.
- When undefined: no CSUM state and no XOR register; DATA goes directly to RELEASE.

Decomposition:
- Shared package/header holds:
  - State encoding localparams (LEN0, LEN1, DATA, CSUM, RELEASE, RUN, ERR).
  - Default ADDR_WIDTH tied to the existing IMEM_ADDR_WIDTH config define.
- One natural sub-module, boot_word_asm: byte counter plus 32-bit shift/assembly register with a word_valid pulse. The FSM, counters and reset control stay in the top.

Test Plan:
- Reset, then bytes 02 00 | 13 00 00 00 | 6F 00 00 00 at one byte per cycle -> writes addr0=0x00000013 and addr1=0x0000006F, each o_imem_we one cycle; o_core_rst_n rises 2 cycles after the last byte; o_done=1.
- Same stream with i_byte_vld toggling randomly -> identical writes and addresses; no duplicated or dropped bytes; o_byte_rdy=0 after RUN.
- Header 00 00 -> no o_imem_we, RUN reached. With BOOT_CSUM_EN, extra byte 00 -> RUN; byte 01 -> ERR.
- ADDR_WIDTH=2, header 05 00 -> ERR, o_core_rst_n stays 0. Header 04 00 plus 16 bytes -> addresses 0..3, RUN.
- BOOT_CSUM_EN, header 01 00, data 11 22 33 44 -> checksum byte 0x44 gives RUN; byte 0x45 gives ERR with the write to addr0 still performed.
- In RUN, pulse i_reload -> o_core_rst_n=0 and o_done=0 next cycle, reload of a new image succeeds. rst_n low mid-DATA -> all outputs at reset values the next cycle.
